// File: rtl/mem_host_arb_pkg.sv
// Shared types and helpers for the N-host SRAM arbiter.
//   arb_mode_e : fixed priority or round-robin selection
//   pend_t     : the single outstanding response slot (valid, host id, error)
//   in_window  : address decode against the SRAM window
package mem_host_arb_pkg;

  localparam int unsigned MaxHosts = 8;
  localparam int unsigned HostIdW  = 3;

  typedef enum logic {
    ArbFixed      = 1'b0,
    ArbRoundRobin = 1'b1
  } arb_mode_e;

  typedef struct packed {
    logic               valid;
    logic [HostIdW-1:0] id;
    logic               err;
  } pend_t;

  // size is a power of two, so masking off the offset bits leaves the window base.
  function automatic logic in_window(input logic [63:0] addr,
                                     input logic [63:0] start,
                                     input logic [63:0] size);
    return (addr & ~(size - 64'd1)) == start;
  endfunction

endpackage

// File: rtl/mem_host_arb_rr.sv
// Combinational host selector with a registered round-robin pointer.
//   clk_i, rst_ni : clock, async active-low reset
//   i_mode        : ArbFixed (lowest index wins) or ArbRoundRobin
//   i_req         : per-host request vector
//   o_gnt         : one-hot grant (zero when nobody requests)
//   o_idx         : index of the granted host
//   o_valid       : a host was granted this cycle
module mem_host_arb_rr
  import mem_host_arb_pkg::*;
#(
  parameter  int unsigned NumHosts = 2,
  localparam int unsigned IdxW     = (NumHosts > 1) ? $clog2(NumHosts) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  arb_mode_e           i_mode,
  input  logic [NumHosts-1:0] i_req,
  output logic [NumHosts-1:0] o_gnt,
  output logic [IdxW-1:0]     o_idx,
  output logic                o_valid
);

  logic [IdxW-1:0] r_ptr;
  logic [IdxW:0]   w_cand;

  // Candidates are visited in priority order; in round-robin mode the order
  // starts just after the last winner and wraps (one subtraction suffices
  // because ptr + k + 1 < 2 * NumHosts).
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int unsigned k = 0; k < NumHosts; k++) begin
      if (i_mode == ArbRoundRobin) begin
        w_cand = {1'b0, r_ptr} + (IdxW+1)'(k + 1);
        if (w_cand >= (IdxW+1)'(NumHosts)) begin
          w_cand = w_cand - (IdxW+1)'(NumHosts);
        end
      end else begin
        w_cand = (IdxW+1)'(k);
      end
      if (!o_valid && i_req[w_cand[IdxW-1:0]]) begin
        o_valid = 1'b1;
        o_idx   = w_cand[IdxW-1:0];
      end
    end
    if (o_valid) begin
      o_gnt[o_idx] = 1'b1;
    end
  end

  // Reset to the last host so host 0 is first in line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= IdxW'(NumHosts - 1);
    end else if (o_valid) begin
      r_ptr <= o_idx;
    end
  end

endmodule

// File: rtl/mem_host_arb.sv
// N-host to single-port SRAM arbiter with window decode and response routing.
//   clk_i, rst_ni           : clock, async active-low reset
//   host_req/we/be/addr/wdata_i : packed per-host OBI-style request channels
//   host_gnt_o              : same-cycle grant, one-hot or zero
//   host_rvalid/err/rdata_o : per-host response, one cycle after the grant
//   mem_req/we/be/addr/wdata_o : SRAM request (all zero unless an in-window winner)
//   mem_rvalid_i, mem_rdata_i  : SRAM response, fixed one-cycle latency
//   protocol_err_o          : sticky flag for an SRAM response nobody asked for
module mem_host_arb
  import mem_host_arb_pkg::*;
#(
  parameter  int unsigned          NumHosts  = 2,
  parameter  int unsigned          AddrWidth = 32,
  parameter  int unsigned          DataWidth = 32,
  parameter  logic [AddrWidth-1:0] MemStart  = '0,
  parameter  int unsigned          MemSize   = 65536,
  parameter  int unsigned          ArbMode   = 0,
  localparam int unsigned          BeW       = DataWidth / 8,
  localparam int unsigned          IdxW      = (NumHosts > 1) ? $clog2(NumHosts) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumHosts-1:0]           host_req_i,
  input  logic [NumHosts-1:0]           host_we_i,
  input  logic [NumHosts*BeW-1:0]       host_be_i,
  input  logic [NumHosts*AddrWidth-1:0] host_addr_i,
  input  logic [NumHosts*DataWidth-1:0] host_wdata_i,
  output logic [NumHosts-1:0]           host_gnt_o,
  output logic [NumHosts-1:0]           host_rvalid_o,
  output logic [NumHosts-1:0]           host_err_o,
  output logic [NumHosts*DataWidth-1:0] host_rdata_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [BeW-1:0]                mem_be_o,
  output logic [AddrWidth-1:0]          mem_addr_o,
  output logic [DataWidth-1:0]          mem_wdata_o,
  input  logic                          mem_rvalid_i,
  input  logic [DataWidth-1:0]          mem_rdata_i,
  output logic                          protocol_err_o
);

  arb_mode_e             w_mode;
  logic [NumHosts-1:0]   w_req;
  logic [NumHosts-1:0]   w_gnt;
  logic [IdxW-1:0]       w_idx;
  logic                  w_any;
  logic                  w_we;
  logic [BeW-1:0]        w_be;
  logic [AddrWidth-1:0]  w_addr;
  logic [DataWidth-1:0]  w_wdata;
  logic                  w_in_range;
  logic                  w_mem_go;
  pend_t                 r_pend;
  logic                  r_protocol_err;

  assign w_mode = (ArbMode == 1) ? ArbRoundRobin : ArbFixed;

  // Requests are masked while reset is held so grants and mem_* stay at zero.
  assign w_req = host_req_i & {NumHosts{rst_ni}};

  mem_host_arb_rr #(
    .NumHosts (NumHosts)
  ) u_rr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_mode  (w_mode),
    .i_req   (w_req),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_valid (w_any)
  );

  always_comb begin
    w_we    = 1'b0;
    w_be    = '0;
    w_addr  = '0;
    w_wdata = '0;
    for (int h = 0; h < NumHosts; h++) begin
      if (w_gnt[h]) begin
        w_we    = host_we_i[h];
        w_be    = host_be_i[h*BeW +: BeW];
        w_addr  = host_addr_i[h*AddrWidth +: AddrWidth];
        w_wdata = host_wdata_i[h*DataWidth +: DataWidth];
      end
    end
  end

  assign w_in_range = in_window(64'(w_addr), 64'(MemStart), 64'(MemSize));
  // Out-of-window winners are still granted but never reach the SRAM.
  assign w_mem_go   = w_any & w_in_range;

  assign host_gnt_o  = w_gnt;
  assign mem_req_o   = w_mem_go;
  assign mem_we_o    = w_mem_go & w_we;
  assign mem_be_o    = w_mem_go ? w_be    : '0;
  assign mem_addr_o  = w_mem_go ? w_addr  : '0;
  assign mem_wdata_o = w_mem_go ? w_wdata : '0;

  // Latency is exactly one cycle, so a single slot is rewritten every cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend         <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      r_pend.valid <= w_any;
      r_pend.id    <= HostIdW'(w_idx);
      r_pend.err   <= ~w_in_range;
      if (mem_rvalid_i && !(r_pend.valid && !r_pend.err)) begin
        r_protocol_err <= 1'b1;
      end
    end
  end

  // Only the pending host sees data; error responses carry zero data.
  always_comb begin
    host_rvalid_o = '0;
    host_err_o    = '0;
    host_rdata_o  = '0;
    for (int h = 0; h < NumHosts; h++) begin
      if (r_pend.valid && (r_pend.id == HostIdW'(h))) begin
        host_rvalid_o[h] = 1'b1;
        host_err_o[h]    = r_pend.err;
        if (!r_pend.err) begin
          host_rdata_o[h*DataWidth +: DataWidth] = mem_rdata_i;
        end
      end
    end
  end

  assign protocol_err_o = r_protocol_err;

endmodule

// File: tb/tb_mem_host_arb.sv
module tb_mem_host_arb;

  localparam int     N         = 3;
  localparam int     AW        = 32;
  localparam int     DW        = 32;
  localparam int     BW        = DW / 8;
  localparam longint MEM_START = 0;
  localparam longint MEM_SIZE  = 65536;
  localparam int     RAM_WORDS = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // host-side stimulus, shared by both DUTs (index 0 = fixed, 1 = round-robin)
  logic [N-1:0]    s_req, s_we;
  logic [BW-1:0]   s_be    [N];
  logic [AW-1:0]   s_addr  [N];
  logic [DW-1:0]   s_wdata [N];
  logic [N*BW-1:0] b_be;
  logic [N*AW-1:0] b_addr;
  logic [N*DW-1:0] b_wdata;
  logic            inject = 1'b0;

  always_comb begin
    b_be = '0; b_addr = '0; b_wdata = '0;
    for (int h = 0; h < N; h++) begin
      b_be[h*BW +: BW]    = s_be[h];
      b_addr[h*AW +: AW]  = s_addr[h];
      b_wdata[h*DW +: DW] = s_wdata[h];
    end
  end

  logic [N-1:0]    o_gnt [2], o_rvalid [2], o_err [2];
  logic [N*DW-1:0] o_rdata [2];
  logic            o_mreq [2], o_mwe [2], o_perr [2];
  logic [BW-1:0]   o_mbe [2];
  logic [AW-1:0]   o_maddr [2];
  logic [DW-1:0]   o_mwdata [2];
  logic            i_mrvalid [2];
  logic [DW-1:0]   i_mrdata [2];
  logic            r_rv [2];

  mem_host_arb #(.NumHosts(N), .AddrWidth(AW), .DataWidth(DW), .MemStart(32'h0),
                 .MemSize(65536), .ArbMode(0)) u_fix (
    .clk_i(clk), .rst_ni(rst_n), .host_req_i(s_req), .host_we_i(s_we), .host_be_i(b_be),
    .host_addr_i(b_addr), .host_wdata_i(b_wdata), .host_gnt_o(o_gnt[0]),
    .host_rvalid_o(o_rvalid[0]), .host_err_o(o_err[0]), .host_rdata_o(o_rdata[0]),
    .mem_req_o(o_mreq[0]), .mem_we_o(o_mwe[0]), .mem_be_o(o_mbe[0]), .mem_addr_o(o_maddr[0]),
    .mem_wdata_o(o_mwdata[0]), .mem_rvalid_i(i_mrvalid[0]), .mem_rdata_i(i_mrdata[0]),
    .protocol_err_o(o_perr[0]));

  mem_host_arb #(.NumHosts(N), .AddrWidth(AW), .DataWidth(DW), .MemStart(32'h0),
                 .MemSize(65536), .ArbMode(1)) u_rr (
    .clk_i(clk), .rst_ni(rst_n), .host_req_i(s_req), .host_we_i(s_we), .host_be_i(b_be),
    .host_addr_i(b_addr), .host_wdata_i(b_wdata), .host_gnt_o(o_gnt[1]),
    .host_rvalid_o(o_rvalid[1]), .host_err_o(o_err[1]), .host_rdata_o(o_rdata[1]),
    .mem_req_o(o_mreq[1]), .mem_we_o(o_mwe[1]), .mem_be_o(o_mbe[1]), .mem_addr_o(o_maddr[1]),
    .mem_wdata_o(o_mwdata[1]), .mem_rvalid_i(i_mrvalid[1]), .mem_rdata_i(i_mrdata[1]),
    .protocol_err_o(o_perr[1]));

  // single-port RAM per DUT, one-cycle read latency, pre-zeroed
  logic [DW-1:0] ram [2][RAM_WORDS];
  bit ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int d = 0; d < 2; d++) for (int i = 0; i < RAM_WORDS; i++) ram[d][i] <= '0;
      ram_init <= 1'b1;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (o_mreq[d]) begin
          i_mrdata[d] <= ram[d][o_maddr[d][9:2]];
          if (o_mwe[d])
            for (int b = 0; b < BW; b++)
              if (o_mbe[d][b]) ram[d][o_maddr[d][9:2]][8*b +: 8] <= o_mwdata[d][8*b +: 8];
        end
      end
    end
    for (int d = 0; d < 2; d++) r_rv[d] <= rst_n && o_mreq[d];
  end
  always_comb for (int d = 0; d < 2; d++) i_mrvalid[d] = r_rv[d] | inject;

  // checking infrastructure
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int            host;
    bit            err;
    bit            wr;
    logic [DW-1:0] rdata;
    longint        cyc;
  } exp_t;

  exp_t   sb [2][$];
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model state
  int            ptr [2];
  bit            prev_inr [2];
  bit            perr_m [2];
  logic [DW-1:0] mm [2][RAM_WORDS];
  bit            mm_init = 1'b0;
  int            m_w;
  bit            m_inr;
  exp_t          m_e;

  function automatic bit in_win(input logic [AW-1:0] a);
    longint v;
    v = longint'({32'h0, a});
    return (v >= MEM_START) && (v < MEM_START + MEM_SIZE);
  endfunction

  function automatic int pick(input int d, input logic [N-1:0] r);
    if (d == 0) begin
      for (int h = 0; h < N; h++) if (r[h]) return h;
      return -1;
    end
    for (int k = 1; k <= N; k++) if (r[(ptr[d] + k) % N]) return (ptr[d] + k) % N;
    return -1;
  endfunction

  // model: predicts grant / SRAM request now and queues the expected response
  always @(negedge clk) begin
    if (!mm_init) begin
      for (int d = 0; d < 2; d++) for (int i = 0; i < RAM_WORDS; i++) mm[d][i] = '0;
      mm_init = 1'b1;
    end
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        sb[d].delete();
        ptr[d] = N - 1;
        prev_inr[d] = 1'b0;
        perr_m[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("d%0d protocol_err", d), 128'(o_perr[d]), 128'(perr_m[d]));
        m_w   = pick(d, s_req);
        m_inr = (m_w >= 0) && in_win(s_addr[m_w]);
        chk($sformatf("d%0d gnt", d), 128'(o_gnt[d]), (m_w >= 0) ? (128'(1) << m_w) : 128'(0));
        chk($sformatf("d%0d mem_req", d), 128'(o_mreq[d]), 128'(m_inr));
        if (m_inr)
          chk($sformatf("d%0d mem_bus", d), 128'({o_mwe[d], o_mbe[d], o_maddr[d], o_mwdata[d]}),
              128'({s_we[m_w], s_be[m_w], s_addr[m_w], s_wdata[m_w]}));
        else
          chk($sformatf("d%0d mem_bus_idle", d),
              128'({o_mwe[d], o_mbe[d], o_maddr[d], o_mwdata[d]}), 128'(0));
        if (m_w >= 0) begin
          m_e.host  = m_w;
          m_e.err   = !m_inr;
          m_e.wr    = s_we[m_w];
          m_e.cyc   = cyc;
          m_e.rdata = m_inr ? mm[d][s_addr[m_w][9:2]] : '0;
          sb[d].push_back(m_e);
          if (m_inr && s_we[m_w])
            for (int b = 0; b < BW; b++)
              if (s_be[m_w][b]) mm[d][s_addr[m_w][9:2]][8*b +: 8] = s_wdata[m_w][8*b +: 8];
          if (d == 1) ptr[d] = m_w;
        end
        if (i_mrvalid[d] && !prev_inr[d]) perr_m[d] = 1'b1;
        prev_inr[d] = m_inr;
      end
    end
  end

  // monitor: whenever a response appears, pop and compare
  exp_t            me;
  logic [N*DW-1:0] exp_rd, rd_mask;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (o_rvalid[d] != '0) begin
          if (sb[d].size() == 0 || sb[d][0].cyc >= cyc) begin
            chk($sformatf("d%0d unexpected_rvalid", d), 128'(o_rvalid[d]), 128'(0));
          end else begin
            me = sb[d].pop_front();
            chk($sformatf("d%0d rvalid", d), 128'(o_rvalid[d]), 128'(1) << me.host);
            chk($sformatf("d%0d err", d), 128'(o_err[d]), me.err ? (128'(1) << me.host) : 128'(0));
            exp_rd  = '0;
            rd_mask = '1;
            if (me.wr && !me.err) rd_mask[me.host*DW +: DW] = '0;
            else exp_rd[me.host*DW +: DW] = me.rdata;
            chk($sformatf("d%0d rdata", d), 128'(o_rdata[d] & rd_mask), 128'(exp_rd));
          end
        end else if (sb[d].size() > 0 && sb[d][0].cyc < cyc) begin
          chk($sformatf("d%0d missing_rvalid", d), 128'(o_rvalid[d]), 128'(1) << sb[d][0].host);
          void'(sb[d].pop_front());
        end
      end
    end
  end

  // stimulus helpers
  task automatic idle();
    s_req = '0; s_we = '0;
    for (int h = 0; h < N; h++) begin s_be[h] = '0; s_addr[h] = '0; s_wdata[h] = '0; end
  endtask

  task automatic host(input int h, input bit we, input logic [BW-1:0] be,
                      input logic [AW-1:0] a, input logic [DW-1:0] wd);
    s_req[h] = 1'b1; s_we[h] = we; s_be[h] = be; s_addr[h] = a; s_wdata[h] = wd;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); rst_n = 1'b0; step(); step(); rst_n = 1'b1;
  endtask

  int rr_a [6] = '{0, 1, 2, 0, 1, 2};
  int rr_b [4] = '{0, 2, 0, 2};

  initial begin
    idle();
    step(); step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d reset_ctrl", d),
          128'({o_gnt[d], o_rvalid[d], o_err[d], o_mreq[d], o_mwe[d], o_mbe[d], o_perr[d]}), 128'(0));
      chk($sformatf("d%0d reset_data", d), 128'({o_rdata[d], o_maddr[d] | o_mwdata[d]}), 128'(0));
    end
    step();
    rst_n = 1'b1;

    // preload two words, then both hosts read simultaneously: host0 first, host1 next
    host(0, 1'b1, 4'hF, 32'h100, 32'h1111_2222); host(1, 1'b1, 4'hF, 32'h200, 32'h3333_4444);
    step();
    s_req[0] = 1'b0;
    step();
    idle(); host(0, 1'b0, 4'hF, 32'h100, 32'h0); host(1, 1'b0, 4'hF, 32'h200, 32'h0);
    step();
    s_req[0] = 1'b0;
    step();
    idle(); step();

    // round-robin order with all three requesting, then with host1 absent
    do_reset();
    for (int h = 0; h < N; h++) host(h, 1'b0, 4'hF, 32'(h) << 2, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); chk("rr_order_all", 128'(o_gnt[1]), 128'(1) << rr_a[i]);
      step();
    end
    // pointer rests on host2, so the search resumes at host0
    s_req[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("rr_order_drop1", 128'(o_gnt[1]), 128'(1) << rr_b[i]);
      step();
    end
    idle(); step();

    // out-of-window write: granted, no SRAM request, error response next cycle
    host(1, 1'b1, 4'hF, 32'h0001_0000, 32'hCAFE_F00D);
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("d%0d oow_mem_req", d), 128'(o_mreq[d]), 128'(0));
    step();
    idle(); step();

    // partial write then read back
    host(0, 1'b1, 4'b0011, 32'h40, 32'hDEAD_BEEF);
    step();
    idle(); host(0, 1'b0, 4'hF, 32'h40, 32'h0);
    step();
    idle();
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("d%0d be_readback", d), 128'(o_rdata[d][31:0]), 128'(32'h0000_BEEF));
    step(); step();

    // stray SRAM response with nothing pending
    inject = 1'b1; step(); inject = 1'b0;
    step(); step(); step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("d%0d protocol_sticky", d), 128'(o_perr[d]), 128'(1));
    step();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      for (int h = 0; h < N; h++) begin
        s_req[h]   = ($urandom_range(0, 99) < 60);
        s_we[h]    = 1'($urandom_range(0, 1));
        s_be[h]    = 4'($urandom_range(0, 15));
        s_wdata[h] = $urandom;
        case ($urandom_range(0, 9))
          0:       s_addr[h] = 32'h0001_0000 + (32'($urandom_range(0, 255)) << 2);
          1:       s_addr[h] = 32'h8000_0000 | (32'($urandom_range(0, 255)) << 2);
          2:       s_addr[h] = 32'h0000_FFFC;
          default: s_addr[h] = 32'($urandom_range(0, 255)) << 2;
        endcase
      end
      step();
    end
    idle(); step(); step();

    // reset in the cycle after a grant: response dropped, host0 first afterwards
    for (int h = 0; h < N; h++) host(h, 1'b0, 4'hF, 32'h100, 32'h0);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("d%0d rst_no_rvalid", d), 128'(o_rvalid[d]), 128'(0));
    step();
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("d%0d post_rst_gnt", d), 128'(o_gnt[d]), 128'(1));
    step();
    idle(); step(); step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
